alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the R/I-type CPU execute path. Accepts one 32-bit
//  MIPS-format instruction per handshake, decodes it, reads the register file,
//  and drives the shared combinational ALU (3-bit alu_op). It then writes the
//  result back and raises done. It sits between fetch and the regfile/ALU pair.
// PARAMETERS
//  DATA_W   32  datapath width; ALU operands, result and regfile data
//  RADDR_W  5   regfile address width
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        reset, synchronous, active-high
//  instr_valid  in   1        instr is presented
//  instr_ready  out  1        controller can accept; 1 only in IDLE
//  instr        in   32       opcode[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0] imm[15:0]
//  rf_raddr_a   out  RADDR_W  read port A address (rs)
//  rf_raddr_b   out  RADDR_W  read port B address (rt)
//  rf_rdata_a   in   DATA_W   port A data; combinational from the address
//  rf_rdata_b   in   DATA_W   port B data; combinational from the address
//  alu_op       out  3        000 and,001 or,010 xor,011 nor,100 add,101 sub,110 sltu,111 shl(b<<a)
//  alu_a        out  DATA_W   ALU data_a
//  alu_b        out  DATA_W   ALU data_b
//  alu_result   in   DATA_W   ALU result; combinational
//  alu_zf       in   1        ALU zero flag
//  rf_we        out  1        write-back strobe; one cycle
//  rf_waddr     out  RADDR_W  write-back address
//  rf_wdata     out  DATA_W   write-back data
//  done         out  1        one-cycle pulse at instruction completion
//  illegal      out  1        one-cycle pulse; an unsupported encoding was dropped
//  zf_q         out  1        registered alu_zf of the last executed instruction
// BEHAVIOUR
//  - States: IDLE -> READ -> EXEC -> WB -> IDLE. Encoding is binary; no other state is reachable.
//  - IDLE: instr_ready=1. On instr_valid, latch instr and go to READ. Without instr_valid, stay in IDLE.
//  - READ: drive rf_raddr_a=rs and rf_raddr_b=rt from the latch; register both operands.
//    - Illegal decode -> pulse illegal, go to IDLE. No ALU/regfile write side effects.
//  - EXEC: drive alu_op, alu_a and alu_b from the registered operands.
//    - Capture alu_result into wdata_q and alu_zf into zf_q; go to WB.
//  - WB: rf_we=1, rf_waddr=dest, rf_wdata=wdata_q, done=1; go to IDLE.
//    - If dest==0, rf_we=0 but done is still pulsed.
//  - Latency: handshake cycle T, READ T+1, EXEC T+2, WB T+3.
//    - Earliest next accept is T+4, so throughput is 1 instruction per 4 cycles.
//  - R-type (opcode 000000), dest=rd, funct -> alu_op:
//    100100 and=000, 100101 or=001, 100110 xor=010, 100111 nor=011,
//    100000 add=100, 100010 sub=101, 101011 sltu=110,
//    000100 sllv=111 with alu_a={0,rs_data[4:0]} and alu_b=rt_data.
//  - I-type, dest=rt, alu_a=rs_data, alu_b=imm:
//    001000 addi=100 with sign-extended imm; 001011 sltiu=110 with sign-extended imm;
//    001100 andi=000, 001101 ori=001, 001110 xori=010, each with zero-extended imm.
//  - Any other opcode or funct is illegal.
//  - Arithmetic wraps modulo 2^DATA_W. There is no overflow trap.
//  - Outside their state, alu_op, alu_a and alu_b are held at 0, and rf_we, done and illegal are 0.
//  - Reset: state=IDLE; every registered output and internal latch=0; instr_ready=1 the cycle after release.
//    - rst has priority in any state. An in-flight instruction is discarded with no rf_we and no done.
//  - instr is sampled only on the accept edge. Changes to instr or instr_valid outside IDLE are ignored.
// TESTING
//  - add r3,r1,r2 with r1=5, r2=7 -> alu_op=100 at T+2; rf_we=1, waddr=3, wdata=12, done=1 at T+3; zf_q=0.
//  - sub r4,r1,r1 with r1=9 -> wdata=0 and zf_q=1. addi r5,r0,0xFFFF -> wdata=0xFFFFFFFF.
//  - ori r6,r0,0x8001 -> zero-extended: wdata=0x00008001.
//    sllv r7,r2,r1 with r1=0x24, r2=1 -> alu_a=4, wdata=0x10.
//  - opcode 111111 -> illegal pulses at T+1, no rf_we, instr_ready=1 at T+2.
//    add r0,r1,r2 -> done=1 with rf_we=0.
//  - instr_valid held high continuously with 3 instructions -> accepts exactly 4 cycles apart;
//    changing instr mid-flight does not alter the result.
//  - rst asserted during EXEC -> no rf_we and no done; all outputs 0 and instr_ready=1 on the following cycle.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Four-state sequencer (IDLE -> READ -> EXEC -> WB) for the R/I-type execute path.
// It accepts one MIPS-format instruction per handshake and reads both source registers.
// It drives the shared combinational ALU, then writes the result back with a done pulse.
// Unsupported encodings are dropped after READ with a one-cycle illegal pulse.

module alu_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instr,
    output logic [RADDR_W-1:0] rf_raddr_a,
    output logic [RADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0]  rf_rdata_a,
    input  logic [DATA_W-1:0]  rf_rdata_b,
    output logic [2:0]         alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zf,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               done,
    output logic               illegal,
    output logic               zf_q
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Decoded view of an instruction word.
    typedef struct packed {
        logic       legal;
        logic [2:0] op;
        logic       use_imm;   // operand B comes from imm instead of rt data
        logic       sext_imm;  // imm is sign-extended (else zero-extended)
        logic       shift_a;   // operand A is only rs_data[4:0] (sllv)
        logic [4:0] dest;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d.legal    = 1'b0;
        d.op       = 3'b000;
        d.use_imm  = 1'b0;
        d.sext_imm = 1'b0;
        d.shift_a  = 1'b0;
        d.dest     = ins[20:16];
        case (ins[31:26])
            6'b000000: begin
                d.dest = ins[15:11];
                case (ins[5:0])
                    6'b100100: begin d.legal = 1'b1; d.op = 3'b000; end
                    6'b100101: begin d.legal = 1'b1; d.op = 3'b001; end
                    6'b100110: begin d.legal = 1'b1; d.op = 3'b010; end
                    6'b100111: begin d.legal = 1'b1; d.op = 3'b011; end
                    6'b100000: begin d.legal = 1'b1; d.op = 3'b100; end
                    6'b100010: begin d.legal = 1'b1; d.op = 3'b101; end
                    6'b101011: begin d.legal = 1'b1; d.op = 3'b110; end
                    6'b000100: begin d.legal = 1'b1; d.op = 3'b111; d.shift_a = 1'b1; end
                    default:   d.legal = 1'b0;
                endcase
            end
            6'b001000: begin d.legal = 1'b1; d.op = 3'b100; d.use_imm = 1'b1; d.sext_imm = 1'b1; end
            6'b001011: begin d.legal = 1'b1; d.op = 3'b110; d.use_imm = 1'b1; d.sext_imm = 1'b1; end
            6'b001100: begin d.legal = 1'b1; d.op = 3'b000; d.use_imm = 1'b1; end
            6'b001101: begin d.legal = 1'b1; d.op = 3'b001; d.use_imm = 1'b1; end
            6'b001110: begin d.legal = 1'b1; d.op = 3'b010; d.use_imm = 1'b1; end
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [31:0]         instr_r;
    logic [RADDR_W-1:0]  waddr_r;
    logic [2:0]          alu_op_r;
    logic [DATA_W-1:0]   alu_a_r;
    logic [DATA_W-1:0]   alu_b_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                zf_r;
    logic                rf_we_r;
    logic                done_r;
    logic                illegal_r;
    logic [DATA_W-1:0]   opa_s;
    logic [DATA_W-1:0]   opb_s;
    dec_t                dec_in_s;
    dec_t                dec_lat_s;

    // The incoming word is decoded at accept so the illegal pulse can be registered for READ.
    assign dec_in_s  = decode(instr);
    assign dec_lat_s = decode(instr_r);

    assign instr_ready = (state_r == ST_IDLE);
    assign rf_raddr_a  = instr_r[25:21];
    assign rf_raddr_b  = instr_r[20:16];
    assign alu_op      = alu_op_r;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign rf_we       = rf_we_r;
    assign rf_waddr    = waddr_r;
    assign rf_wdata    = wdata_r;
    assign done        = done_r;
    assign illegal     = illegal_r;
    assign zf_q        = zf_r;

    // State register; reset returns to IDLE from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an illegal word leaves READ straight back to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (dec_lat_s.legal) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: state_s = ST_WB;
            ST_WB:   state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand selection from the register-file read data and the latched immediate.
    always_comb begin
        opa_s = rf_rdata_a;
        opb_s = rf_rdata_b;
        if (dec_lat_s.shift_a) begin
            opa_s = {{(DATA_W-5){1'b0}}, rf_rdata_a[4:0]};
        end else begin
            opa_s = rf_rdata_a;
        end
        if (dec_lat_s.use_imm) begin
            if (dec_lat_s.sext_imm) begin
                opb_s = {{(DATA_W-16){instr_r[15]}}, instr_r[15:0]};
            end else begin
                opb_s = {{(DATA_W-16){1'b0}}, instr_r[15:0]};
            end
        end else begin
            opb_s = rf_rdata_b;
        end
    end

    // Accept latch, ALU staging in EXEC, result capture and the one-cycle WB/illegal pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r   <= 32'd0;
            waddr_r   <= {RADDR_W{1'b0}};
            alu_op_r  <= 3'b000;
            alu_a_r   <= {DATA_W{1'b0}};
            alu_b_r   <= {DATA_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            zf_r      <= 1'b0;
            rf_we_r   <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            alu_op_r  <= 3'b000;
            alu_a_r   <= {DATA_W{1'b0}};
            alu_b_r   <= {DATA_W{1'b0}};
            rf_we_r   <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_r   <= instr;
                        waddr_r   <= dec_in_s.dest;
                        illegal_r <= ~dec_in_s.legal;
                    end
                end
                ST_READ: begin
                    if (dec_lat_s.legal) begin
                        alu_op_r <= dec_lat_s.op;
                        alu_a_r  <= opa_s;
                        alu_b_r  <= opb_s;
                    end
                end
                ST_EXEC: begin
                    wdata_r <= alu_result;
                    zf_r    <= alu_zf;
                    rf_we_r <= (waddr_r != {RADDR_W{1'b0}});
                    done_r  <= 1'b1;
                end
                ST_WB: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: bench-owned register file and ALU, a cycle model of the
// instruction semantics compared on every negedge, and literal checks on directed cases.

module tb_alu_seq_ctrl;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;

    logic               clk;
    logic               rst;
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr;
    logic [RADDR_W-1:0] rf_raddr_a;
    logic [RADDR_W-1:0] rf_raddr_b;
    logic [DATA_W-1:0]  rf_rdata_a;
    logic [DATA_W-1:0]  rf_rdata_b;
    logic [2:0]         alu_op;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_zf;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic               done;
    logic               illegal;
    logic               zf_q;

    logic [31:0] rf [32];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [2:0]  cap_op    [5];
    logic [31:0] cap_a     [5];
    logic [31:0] cap_wdata [5];
    logic [4:0]  cap_waddr [5];
    logic        cap_we    [5];
    logic        cap_done  [5];
    logic        cap_ill   [5];
    logic        cap_ready [5];
    logic        cap_zf    [5];

    alu_seq_ctrl #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zf(alu_zf),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .done(done), .illegal(illegal), .zf_q(zf_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Register file read ports (combinational).
    always_comb begin
        rf_rdata_a = rf[rf_raddr_a];
        rf_rdata_b = rf[rf_raddr_b];
    end

    // Shared combinational ALU.
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a ^ alu_b;
            3'b011:  alu_result = ~(alu_a | alu_b);
            3'b100:  alu_result = alu_a + alu_b;
            3'b101:  alu_result = alu_a - alu_b;
            3'b110:  alu_result = {31'd0, (alu_a < alu_b)};
            3'b111:  alu_result = alu_b << alu_a[4:0];
            default: alu_result = 32'd0;
        endcase
    end
    assign alu_zf = (alu_result == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Instruction semantics: what the ALU must be fed and what must be written back.
    task automatic model_exec(input logic [31:0] ins, output logic legal, output logic [2:0] op,
                              output logic [31:0] a, output logic [31:0] b,
                              output logic [31:0] res, output logic [4:0] dest);
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] simm;
        logic [31:0] zimm;
        rs_d  = rf[ins[25:21]];
        rt_d  = rf[ins[20:16]];
        simm  = {{16{ins[15]}}, ins[15:0]};
        zimm  = {16'd0, ins[15:0]};
        legal = 1'b1;
        a     = rs_d;
        b     = rt_d;
        op    = 3'b000;
        res   = 32'd0;
        dest  = ins[20:16];
        if (ins[31:26] == 6'b000000) begin
            dest = ins[15:11];
            case (ins[5:0])
                6'b100100: begin op = 3'b000; res = rs_d & rt_d; end
                6'b100101: begin op = 3'b001; res = rs_d | rt_d; end
                6'b100110: begin op = 3'b010; res = rs_d ^ rt_d; end
                6'b100111: begin op = 3'b011; res = ~(rs_d | rt_d); end
                6'b100000: begin op = 3'b100; res = rs_d + rt_d; end
                6'b100010: begin op = 3'b101; res = rs_d - rt_d; end
                6'b101011: begin op = 3'b110; res = (rs_d < rt_d) ? 32'd1 : 32'd0; end
                6'b000100: begin op = 3'b111; a = {27'd0, rs_d[4:0]}; res = rt_d << rs_d[4:0]; end
                default:   legal = 1'b0;
            endcase
        end else begin
            case (ins[31:26])
                6'b001000: begin op = 3'b100; b = simm; res = rs_d + simm; end
                6'b001011: begin op = 3'b110; b = simm; res = (rs_d < simm) ? 32'd1 : 32'd0; end
                6'b001100: begin op = 3'b000; b = zimm; res = rs_d & zimm; end
                6'b001101: begin op = 3'b001; b = zimm; res = rs_d | zimm; end
                6'b001110: begin op = 3'b010; b = zimm; res = rs_d ^ zimm; end
                default:   legal = 1'b0;
            endcase
        end
    endtask

    // Cycle model and compare: `age` counts cycles since the accepting handshake.
    initial begin : model_cmp
        int          age;
        logic        live;
        logic        after_rst;
        logic        m_legal;
        logic        m_zf;
        logic [2:0]  m_op;
        logic [31:0] m_a;
        logic [31:0] m_b;
        logic [31:0] m_res;
        logic [4:0]  m_dest;
        logic [4:0]  m_rs;
        logic [4:0]  m_rt;
        age = 0; live = 1'b0; after_rst = 1'b0; m_zf = 1'b0; m_legal = 1'b0;
        m_op = 3'b000; m_a = 32'd0; m_b = 32'd0; m_res = 32'd0;
        m_dest = 5'd0; m_rs = 5'd0; m_rt = 5'd0;
        forever begin
            @(negedge clk);
            if (live && after_rst) begin
                chk("rst_ready", 32'(instr_ready), 32'd1);
                chk("rst_illegal", 32'(illegal), 32'd0);
                chk("rst_rf_we", 32'(rf_we), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_alu_op", 32'(alu_op), 32'd0);
                chk("rst_alu_a", alu_a, 32'd0);
                chk("rst_alu_b", alu_b, 32'd0);
                chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
                chk("rst_rf_wdata", rf_wdata, 32'd0);
                chk("rst_raddr_a", 32'(rf_raddr_a), 32'd0);
                chk("rst_raddr_b", 32'(rf_raddr_b), 32'd0);
                chk("rst_zf_q", 32'(zf_q), 32'd0);
            end else if (live) begin
                chk("m_ready", 32'(instr_ready), 32'(age == 0));
                chk("m_illegal", 32'(illegal), 32'(age == 1 && !m_legal));
                chk("m_alu_op", 32'(alu_op), (age == 2) ? 32'(m_op) : 32'd0);
                chk("m_alu_a", alu_a, (age == 2) ? m_a : 32'd0);
                chk("m_alu_b", alu_b, (age == 2) ? m_b : 32'd0);
                chk("m_rf_we", 32'(rf_we), 32'(age == 3 && m_dest != 5'd0));
                chk("m_done", 32'(done), 32'(age == 3));
                chk("m_zf_q", 32'(zf_q), 32'(m_zf));
                if (age == 1) begin
                    chk("m_raddr_a", 32'(rf_raddr_a), 32'(m_rs));
                    chk("m_raddr_b", 32'(rf_raddr_b), 32'(m_rt));
                end
                if (age == 3) begin
                    chk("m_rf_wdata", rf_wdata, m_res);
                    if (m_dest != 5'd0) chk("m_rf_waddr", 32'(rf_waddr), 32'(m_dest));
                end
            end
            // Advance with the inputs the next rising edge will sample.
            if (rst) begin
                live = 1'b1; after_rst = 1'b1; age = 0; m_zf = 1'b0;
            end else if (live) begin
                after_rst = 1'b0;
                case (age)
                    0: if (instr_valid) begin
                           model_exec(instr, m_legal, m_op, m_a, m_b, m_res, m_dest);
                           m_rs = instr[25:21];
                           m_rt = instr[20:16];
                           age = 1;
                       end
                    1: age = m_legal ? 2 : 0;
                    2: begin age = 3; m_zf = (m_res == 32'd0); end
                    default: age = 0;
                endcase
            end
        end
    end

    // One handshake; outputs captured on the negedges of T+1..T+4. Ends at T+5 in IDLE.
    task automatic issue(input logic [31:0] ins);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 32'hFFFF_FFFF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cap_op[k] = alu_op; cap_a[k] = alu_a; cap_wdata[k] = rf_wdata;
            cap_waddr[k] = rf_waddr; cap_we[k] = rf_we; cap_done[k] = done;
            cap_ill[k] = illegal; cap_ready[k] = instr_ready; cap_zf[k] = zf_q;
        end
        @(posedge clk); #1;
    endtask

    logic [31:0] extra [8];
    logic [31:0] tp [3];
    int acc_cyc [3];
    int n_acc;
    int since;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst = 1'b1; instr_valid = 1'b0; instr = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        @(posedge clk); #1;

        // add r3,r1,r2
        rf[1] = 32'd5; rf[2] = 32'd7;
        issue(rtype(5'd1, 5'd2, 5'd3, 6'b100000));
        chk("add_op_t2", 32'(cap_op[2]), 32'h4);
        chk("add_we_t3", 32'(cap_we[3]), 32'd1);
        chk("add_waddr_t3", 32'(cap_waddr[3]), 32'd3);
        chk("add_wdata_t3", cap_wdata[3], 32'd12);
        chk("add_done_t3", 32'(cap_done[3]), 32'd1);
        chk("add_zf", 32'(cap_zf[3]), 32'd0);

        // sub r4,r1,r1
        rf[1] = 32'd9;
        issue(rtype(5'd1, 5'd1, 5'd4, 6'b100010));
        chk("sub_wdata", cap_wdata[3], 32'd0);
        chk("sub_zf", 32'(cap_zf[3]), 32'd1);

        // addi r5,r0,0xFFFF
        issue(itype(6'b001000, 5'd0, 5'd5, 16'hFFFF));
        chk("addi_wdata", cap_wdata[3], 32'hFFFF_FFFF);

        // ori r6,r0,0x8001
        issue(itype(6'b001101, 5'd0, 5'd6, 16'h8001));
        chk("ori_wdata", cap_wdata[3], 32'h0000_8001);

        // sllv r7,r2,r1
        rf[1] = 32'h24; rf[2] = 32'd1;
        issue(rtype(5'd1, 5'd2, 5'd7, 6'b000100));
        chk("sllv_alu_a", cap_a[2], 32'd4);
        chk("sllv_wdata", cap_wdata[3], 32'h10);

        // unsupported opcode
        issue(itype(6'b111111, 5'd1, 5'd2, 16'h1234));
        chk("ill_pulse_t1", 32'(cap_ill[1]), 32'd1);
        chk("ill_ready_t2", 32'(cap_ready[2]), 32'd1);
        chk("ill_we_t3", 32'(cap_we[3]), 32'd0);
        chk("ill_done_t3", 32'(cap_done[3]), 32'd0);

        // add r0,r1,r2
        issue(rtype(5'd1, 5'd2, 5'd0, 6'b100000));
        chk("r0_done", 32'(cap_done[3]), 32'd1);
        chk("r0_we", 32'(cap_we[3]), 32'd0);

        // remaining encodings, checked by the model only
        extra[0] = rtype(5'd1, 5'd2, 5'd11, 6'b100111);          // nor
        extra[1] = itype(6'b001011, 5'd2, 5'd12, 16'hFFFF);      // sltiu
        extra[2] = itype(6'b001110, 5'd1, 5'd13, 16'hFFFF);      // xori
        extra[3] = rtype(5'd1, 5'd2, 5'd14, 6'b100100);          // and
        extra[4] = rtype(5'd1, 5'd2, 5'd15, 6'b100101);          // or
        extra[5] = rtype(5'd2, 5'd1, 5'd16, 6'b101011);          // sltu
        extra[6] = rtype(5'd1, 5'd2, 5'd17, 6'b000000);          // bad funct
        extra[7] = itype(6'b001011, 5'd1, 5'd18, 16'h0010);      // sltiu false
        for (int i = 0; i < 8; i++) issue(extra[i]);

        // back-to-back with instr_valid held high; instr scrambled mid-flight
        tp[0] = rtype(5'd1, 5'd2, 5'd8, 6'b100110);              // xor
        tp[1] = itype(6'b001100, 5'd1, 5'd9, 16'h00F0);          // andi
        tp[2] = rtype(5'd2, 5'd1, 5'd10, 6'b101011);             // sltu
        n_acc = 0; since = -1;
        instr = tp[0]; instr_valid = 1'b1;
        for (int c = 0; c < 40 && n_acc < 3; c++) begin
            @(negedge clk);
            if (instr_ready === 1'b1) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                since = 0;
            end
            @(posedge clk); #1;
            if (since >= 0) since++;
            if (since == 1 && n_acc < 3) instr = 32'hDEAD_BEEF;
            if (since == 3 && n_acc < 3) instr = tp[n_acc];
        end
        instr_valid = 1'b0;
        instr = 32'd0;
        chk("tp_accepts", 32'(n_acc), 32'd3);
        if (n_acc == 3) begin
            chk("tp_gap_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
            chk("tp_gap_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        end
        repeat (4) @(posedge clk);
        #1;

        // reset during EXEC
        rf[1] = 32'd5; rf[2] = 32'd7;
        instr = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstx_ready", 32'(instr_ready), 32'd1);
        chk("rstx_we", 32'(rf_we), 32'd0);
        chk("rstx_done", 32'(done), 32'd0);
        chk("rstx_alu_op", 32'(alu_op), 32'd0);
        chk("rstx_wdata", rf_wdata, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstx_no_done", 32'(done), 32'd0);
            chk("rstx_no_we", 32'(rf_we), 32'd0);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
